// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared constants for the SRAM-backed FIFO controller.
package sram_fifo_ctrl_pkg;

    // External async SRAM geometry.
    localparam int unsigned SRAM_DATA_W = 16;
    localparam int unsigned SRAM_ADDR_W = 20;

    // Requester slots of the round-robin arbiter.
    localparam int unsigned ReqWr = 0;
    localparam int unsigned ReqRd = 1;

endpackage

// File: rtl/sram_fifo_ctrl_rr.sv
// Two-requester round-robin arbiter: a tie goes to the side not granted last.
module sram_rr_arb
    import sram_fifo_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    // 1 when the most recent accepted grant was the read side.
    logic last_rd_q, last_rd_d;

    // Grant decode: single requester wins outright, a tie flips on history.
    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o[ReqWr] = 1'b1;
            2'b10:   grant_o[ReqRd] = 1'b1;
            2'b11: begin
                if (last_rd_q) grant_o[ReqWr] = 1'b1;
                else           grant_o[ReqRd] = 1'b1;
            end
            default: grant_o = 2'b00;
        endcase
    end

    // History only moves when the grant is actually taken.
    always_comb begin
        last_rd_d = last_rd_q;
        if (advance_i && (grant_o != 2'b00)) last_rd_d = grant_o[ReqRd];
    end

    // History register; resets to READ so the first tie goes to WRITE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_rd_q <= 1'b1;
        else         last_rd_q <= last_rd_d;
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Deep FIFO built on one external async SRAM; each access takes two clocks.
module sram_fifo_ctrl
    import sram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2   = SRAM_ADDR_W,
    parameter int unsigned AFULL_MARGIN = 256
) (
    input  logic                   bus_clk_i,
    input  logic                   bus_rst_b_i,
    input  logic [SRAM_DATA_W-1:0] wr_data_i,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    output logic [SRAM_DATA_W-1:0] rd_data_o,
    output logic                   rd_valid_o,
    input  logic                   rd_ready_i,
    output logic [DEPTH_LOG2:0]    fifo_size_o,
    output logic                   full_o,
    output logic                   almost_full_o,
    output logic [DEPTH_LOG2-1:0]  sram_a_o,
    inout  wire  [SRAM_DATA_W-1:0] sram_io_io,
    output logic                   sram_ce1_b_o,
    output logic                   sram_oe_b_o,
    output logic                   sram_we_b_o,
    output logic                   sram_bhe_b_o,
    output logic                   sram_ble_b_o
);

    localparam int unsigned CntW = DEPTH_LOG2 + 1;
    localparam logic [CntW-1:0] Capacity    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [CntW-1:0] AfullMargin = CntW'(AFULL_MARGIN);

    typedef enum logic [2:0] {StIdle, StW1, StW2, StR1, StR2} state_e;

    state_e                 state_q, state_d;
    logic [DEPTH_LOG2-1:0]  wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [SRAM_DATA_W-1:0] wdata_q, wdata_d;
    logic [SRAM_DATA_W-1:0] rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;

    logic [1:0] req;
    logic [1:0] grant;
    logic       in_idle;
    logic       io_oe;

    assign full_o        = (cnt_q == Capacity);
    assign almost_full_o = ((Capacity - cnt_q) <= AfullMargin);
    assign fifo_size_o   = cnt_q + {{DEPTH_LOG2{1'b0}}, rd_valid_q};
    assign rd_data_o     = rd_data_q;
    assign rd_valid_o    = rd_valid_q;

    assign req[ReqWr] = wr_valid_i & ~full_o;
    assign req[ReqRd] = (cnt_q != '0) & (~rd_valid_q | rd_ready_i);
    assign in_idle    = (state_q == StIdle);
    assign wr_ready_o = in_idle & grant[ReqWr];

    sram_rr_arb u_arb (
        .clk_i     (bus_clk_i),
        .rst_ni    (bus_rst_b_i),
        .req_i     (req),
        .advance_i (in_idle),
        .grant_o   (grant)
    );

    // Sequencer: IDLE launches a 2-clock write or read; pointers/count move on completion.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;

        if (rd_valid_q && rd_ready_i) rd_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant[ReqWr]) begin
                    state_d = StW1;
                    wdata_d = wr_data_i;
                end else if (grant[ReqRd]) begin
                    state_d = StR1;
                end
            end
            StW1: state_d = StW2;
            StW2: begin
                state_d = StIdle;
                wptr_d  = wptr_q + 1'b1;
                cnt_d   = cnt_q + 1'b1;
            end
            StR1: state_d = StR2;
            StR2: begin
                // A commit here wins over a same-cycle consume.
                state_d    = StIdle;
                rptr_d     = rptr_q + 1'b1;
                cnt_d      = cnt_q - 1'b1;
                rd_data_d  = sram_io_io;
                rd_valid_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // SRAM strobes decoded from state so reset releases the bus asynchronously.
    always_comb begin
        sram_a_o     = '0;
        sram_ce1_b_o = 1'b1;
        sram_oe_b_o  = 1'b1;
        sram_we_b_o  = 1'b1;
        io_oe        = 1'b0;
        unique case (state_q)
            StW1: begin
                sram_a_o     = wptr_q;
                sram_ce1_b_o = 1'b0;
                sram_we_b_o  = 1'b0;
                io_oe        = 1'b1;
            end
            StW2: begin
                sram_a_o     = wptr_q;
                sram_ce1_b_o = 1'b0;
                io_oe        = 1'b1;
            end
            StR1, StR2: begin
                sram_a_o     = rptr_q;
                sram_ce1_b_o = 1'b0;
                sram_oe_b_o  = 1'b0;
            end
            default: io_oe = 1'b0;
        endcase
    end

    assign sram_bhe_b_o = sram_ce1_b_o;
    assign sram_ble_b_o = sram_ce1_b_o;
    assign sram_io_io   = io_oe ? wdata_q : 'z;

    // State, pointers, count and output register.
    always_ff @(posedge bus_clk_i or negedge bus_rst_b_i) begin
        if (!bus_rst_b_i) begin
            state_q    <= StIdle;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl with a 16-word SRAM model and a queue-based FIFO model.
module tb_sram_fifo_ctrl;

    localparam int unsigned DL  = 4;
    localparam int          CAP = 16;
    localparam int          AFM = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [15:0]    wr_data;
    logic           wr_valid, wr_ready;
    logic [15:0]    rd_data;
    logic           rd_valid, rd_ready;
    logic [DL:0]    fifo_size;
    logic           full, afull;
    logic [DL-1:0]  sram_a;
    wire  [15:0]    sram_io;
    logic           ce_b, oe_b, we_b, bhe_b, ble_b;

    always #5 clk = ~clk;

    sram_fifo_ctrl #(
        .DEPTH_LOG2   (DL),
        .AFULL_MARGIN (AFM)
    ) dut (
        .bus_clk_i     (clk),
        .bus_rst_b_i   (rst_n),
        .wr_data_i     (wr_data),
        .wr_valid_i    (wr_valid),
        .wr_ready_o    (wr_ready),
        .rd_data_o     (rd_data),
        .rd_valid_o    (rd_valid),
        .rd_ready_i    (rd_ready),
        .fifo_size_o   (fifo_size),
        .full_o        (full),
        .almost_full_o (afull),
        .sram_a_o      (sram_a),
        .sram_io_io    (sram_io),
        .sram_ce1_b_o  (ce_b),
        .sram_oe_b_o   (oe_b),
        .sram_we_b_o   (we_b),
        .sram_bhe_b_o  (bhe_b),
        .sram_ble_b_o  (ble_b)
    );

    // Async SRAM model: captures while selected and write-enabled, drives on output-enable.
    logic [15:0] mem [CAP];
    always @(posedge clk) if (!ce_b && !we_b) mem[sram_a] <= sram_io;
    assign sram_io = (!ce_b && !oe_b) ? mem[sram_a] : 16'hzzzz;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] src_q[$];
    logic [15:0] model_q[$];
    logic [15:0] cons_log[$];
    byte         acc_log[$];
    int          infl, rd_mode, we_low_cnt, afull_first;
    bit          acc_seen, prev_hold, prev_oe_low, log_en, rst_at_w1, wr_addr_seen;
    logic [15:0] prev_data;
    logic [DL-1:0] first_wr_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the queue model; a write counts in FIFO_SIZE
    // only once its two SRAM clocks have completed.
    task automatic sample();
        int exp_size, exp_cnt;
        if (!rst_n) begin
            model_q.delete();
            infl        = 0;
            prev_hold   = 1'b0;
            acc_seen    = 1'b0;
            prev_oe_low = 1'b0;
        end else begin
            exp_size = model_q.size() - ((infl > 0) ? 1 : 0);
            exp_cnt  = exp_size - (rd_valid ? 1 : 0);
            chk("we_oe_exclusive", 32'(!we_b && !oe_b), 32'd0);
            chk("byte_enables", 32'({bhe_b, ble_b}), 32'({ce_b, ce_b}));
            chk("fifo_size", 32'(fifo_size), 32'(exp_size));
            chk("full", 32'(full), 32'(exp_cnt == CAP));
            chk("almost_full", 32'(afull), 32'((CAP - exp_cnt) <= AFM));
            chk("wr_ready_when_full", 32'(wr_ready && full), 32'd0);
            if (prev_hold) begin
                chk("rd_hold_valid", 32'(rd_valid), 32'd1);
                chk("rd_hold_data", 32'(rd_data), 32'(prev_data));
            end
            if (rd_valid && rd_ready) begin
                chk("rd_model_nonempty", 32'(model_q.size() > 0), 32'd1);
                if (model_q.size() > 0) begin
                    chk("rd_data_order", 32'(rd_data), 32'(model_q[0]));
                    void'(model_q.pop_front());
                end
                cons_log.push_back(rd_data);
            end
            if (infl > 0) infl--;
            if (wr_valid && wr_ready) begin
                model_q.push_back(wr_data);
                infl = 2;
            end
            if (afull && afull_first < 0) afull_first = int'(fifo_size);
            if (!we_b) begin
                we_low_cnt++;
                if (!wr_addr_seen) begin
                    first_wr_addr = sram_a;
                    wr_addr_seen  = 1'b1;
                end
            end
            if (log_en) begin
                if (!we_b) acc_log.push_back("W");
                if (!oe_b && !prev_oe_low) acc_log.push_back("R");
            end
            prev_oe_low = !oe_b;
            acc_seen    = wr_valid && wr_ready;
            prev_hold   = rd_valid && !rd_ready;
            prev_data   = rd_data;
        end
    endtask

    task automatic drive();
        if (acc_seen && src_q.size() > 0) void'(src_q.pop_front());
        acc_seen = 1'b0;
        wr_valid = (src_q.size() > 0);
        wr_data  = wr_valid ? src_q[0] : 16'h0000;
        case (rd_mode)
            0:       rd_ready = 1'b0;
            1:       rd_ready = 1'b1;
            default: rd_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
        if (rst_at_w1 && !we_b) begin
            #1;
            rst_n    = 1'b0;
            wr_valid = 1'b0;
            src_q.delete();
            #1;
            chk("rst_mid_w1_we_b", 32'(we_b), 32'd1);
            chk("rst_mid_w1_ce_b", 32'(ce_b), 32'd1);
            chk("rst_mid_w1_addr", 32'(sram_a), 32'd0);
            rst_at_w1 = 1'b0;
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input string name, input int max_cycles);
        int k = 0;
        while ((src_q.size() > 0 || model_q.size() > 0 || wr_valid) && k < max_cycles) begin
            cycle();
            k++;
        end
        chk(name, 32'(k < max_cycles), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, n_w, k;
        rst_n = 1'b0; wr_valid = 1'b1; wr_data = 16'h1234; rd_ready = 1'b0;
        rd_mode = 0; infl = 0; afull_first = -1; we_low_cnt = 0;
        acc_seen = 0; prev_hold = 0; prev_oe_low = 0; log_en = 0; rst_at_w1 = 0;
        wr_addr_seen = 0; prev_data = '0; first_wr_addr = '0;

        // 1: reset state
        #12;
        chk("reset_ce_b", 32'(ce_b), 32'd1);
        chk("reset_oe_b", 32'(oe_b), 32'd1);
        chk("reset_we_b", 32'(we_b), 32'd1);
        chk("reset_addr", 32'(sram_a), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        chk("reset_fifo_size", 32'(fifo_size), 32'd0);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_wr_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b0;
        #10 rst_n = 1'b1;

        // 2: three words straight through
        we_low_cnt = 0; cons_log.delete();
        src_q.push_back(16'h1111); src_q.push_back(16'h2222); src_q.push_back(16'h3333);
        rd_mode = 1;
        drain("t2_drain", 200);
        chk("t2_count", 32'(cons_log.size()), 32'd3);
        chk("t2_word0", 32'(cons_log[0]), 32'h1111);
        chk("t2_word1", 32'(cons_log[1]), 32'h2222);
        chk("t2_word2", 32'(cons_log[2]), 32'h3333);
        chk("t2_we_low_cycles", 32'(we_low_cnt), 32'd3);
        chk("t2_fifo_size", 32'(fifo_size), 32'd0);

        // 3: fill with consumer stalled
        rd_mode = 0; afull_first = -1;
        for (int i = 0; i < 20; i++) src_q.push_back(16'h3000 + 16'(i));
        repeat (150) cycle();
        chk("t3_fifo_size", 32'(fifo_size), 32'd17);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_almost_full", 32'(afull), 32'd1);
        chk("t3_wr_ready", 32'(wr_ready), 32'd0);
        chk("t3_afull_first_size", 32'(afull_first), 32'd15);
        chk("t3_pending_words", 32'(src_q.size()), 32'd3);
        rd_mode = 1;
        drain("t3_drain", 400);

        // 4: contention alternates W and R
        rd_mode = 0;
        for (int i = 0; i < 4; i++) src_q.push_back(16'h4000 + 16'(i));
        repeat (40) cycle();
        chk("t4_prefill_size", 32'(fifo_size), 32'd4);
        acc_log.delete(); log_en = 1'b1;
        for (int i = 0; i < 12; i++) src_q.push_back(16'h4100 + 16'(i));
        rd_mode = 1;
        repeat (40) cycle();
        log_en = 1'b0;
        bad = 0; n_w = 0;
        foreach (acc_log[i]) begin
            if (acc_log[i] == "W") n_w++;
            if (i > 0 && acc_log[i] == acc_log[i-1]) bad++;
        end
        chk("t4_access_count", 32'(acc_log.size() >= 8), 32'd1);
        chk("t4_alternation", 32'(bad), 32'd0);
        chk("t4_writes_served", 32'(n_w >= 4), 32'd1);
        drain("t4_drain", 400);

        // 5: 40 words across two pointer wraps, random consumer
        rd_mode = 2; cons_log.delete();
        for (int i = 0; i < 40; i++) src_q.push_back(16'(i));
        drain("t5_drain", 2000);
        chk("t5_count", 32'(cons_log.size()), 32'd40);
        chk("t5_first", 32'(cons_log[0]), 32'h0000);
        chk("t5_after_wrap", 32'(cons_log[16]), 32'h0010);
        chk("t5_last", 32'(cons_log[39]), 32'h0027);

        // 6: reset during W1 discards the word
        rd_mode = 0;
        src_q.push_back(16'hBEEF);
        rst_at_w1 = 1'b1;
        k = 0;
        while (rst_at_w1 && k < 50) begin
            cycle();
            k++;
        end
        chk("t6_reset_injected", 32'(rst_at_w1), 32'd0);
        cycle(); cycle();
        rst_n = 1'b1;
        cycle();
        chk("t6_fifo_size", 32'(fifo_size), 32'd0);
        chk("t6_rd_valid", 32'(rd_valid), 32'd0);
        wr_addr_seen = 1'b0; cons_log.delete();
        src_q.push_back(16'h5A5A);
        rd_mode = 1;
        drain("t6_drain", 100);
        chk("t6_write_seen", 32'(wr_addr_seen), 32'd1);
        chk("t6_write_addr", 32'(first_wr_addr), 32'd0);
        chk("t6_count", 32'(cons_log.size()), 32'd1);
        chk("t6_word", 32'(cons_log[0]), 32'h5A5A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
